// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between pc_sequencer (master) and imem (slave).
// Combinational wires only; req/ack with ack meaningful only while req is high.
// Backpressure: memory holds off a fetch simply by withholding imem_ack.
interface pc_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns pc, drives the PC adder, sequences req/ack fetches to decode.
// Latency: request the cycle after reset exit; instr_valid the cycle after an accepted ack.
// Backpressure: stall drops imem_req and holds pc; optional odd-target trap via PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [15:0]           br_target,
    input  logic                  halt,
    input  logic                  resume,
    output logic [15:0]           pc_inc_addr,
    input  logic [15:0]           pc_inc_sum,
    pc_sequencer_if.master        imem,
    output logic                  instr_valid,
    output logic [15:0]           instr,
    output logic [15:0]           instr_pc,
    output logic                  halted,
    output logic [15:0]           fetch_count,
    output logic                  misalign_err
);

    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic        ack_ok;
    logic        deliver;
    logic        err_set;

    assign pc_inc_addr    = pc;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = (state == FETCH) && !stall;
    assign ack_ok         = imem.imem_ack && imem.imem_req;
    assign halted         = (state == HALT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        deliver   = 1'b0;
        err_set   = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (br_taken) begin
                    // Redirect wins: any same-cycle ack belongs to the abandoned fetch.
`ifdef PC_ALIGN_CHECK_EN
                    if (br_target[0]) begin
                        err_set   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = br_target;
                    end
`else
                    pc_nxt = {br_target[15:1], 1'b0};
`endif
                end else if (halt) begin
                    if (ack_ok) begin
                        deliver = 1'b1;
                        pc_nxt  = pc_inc_sum;
                    end
                    state_nxt = HALT;
                end else if (ack_ok) begin
                    deliver = 1'b1;
                    pc_nxt  = pc_inc_sum;
                end
            end
            HALT: begin
                if (br_taken) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (br_target[0]) err_set = 1'b1;
                    else              pc_nxt  = br_target;
`else
                    pc_nxt = {br_target[15:1], 1'b0};
`endif
                end
                if (resume && !halt && !err_set) state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            fetch_count <= 16'h0000;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= deliver;
            if (deliver) begin
                instr       <= imem.imem_rdata;
                instr_pc    <= pc;
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       misalign_err <= 1'b0;
        else if (err_set) misalign_err <= 1'b1;
    end
`else
    logic unused_err_set;
    assign unused_err_set = err_set;
    assign misalign_err   = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the 16-bit fetch path: owns the PC register, drives the shared PC adder, and sequences instruction fetches over a req/ack memory handshake. Resolves branch redirects, pipeline stalls and halt/resume, and delivers each fetched instruction with its address to decode. Sits between the PC adder, instruction memory and the decode stage.

## Interface
- RESET_VECTOR, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode back-pressure; suppresses fetch while high
- br_taken  in  1  redirect strobe, one cycle
- br_target  in  16  redirect destination
- halt  in  1  request to stop fetching
- resume  in  1  restart fetching from HALT
- pc_inc_addr  out  16  operand to PC adder (= current pc, combinational)
- pc_inc_sum  in  16  PC adder result (pc_inc_addr + 2, combinational)
- imem_req  out  1  fetch request
- imem_addr  out  16  fetch address (= pc)
- imem_ack  in  1  memory completion; valid only while imem_req=1
- imem_rdata  in  16  instruction word, valid with imem_ack
- instr_valid  out  1  one-cycle pulse: instr/instr_pc valid
- instr  out  16  registered instruction word
- instr_pc  out  16  address of instr
- halted  out  1  high in HALT state
- fetch_count  out  16  instructions delivered, wraps at 16'hFFFF -> 0
- misalign_err  out  1  sticky odd-target error

## Operation
- States: BOOT, FETCH, HALT. Reset -> BOOT; BOOT -> FETCH unconditionally next edge.
- imem_req = (state==FETCH) && !stall; imem_addr = pc. imem_ack ignored when imem_req=0.
- In FETCH, per cycle, priority high to low:
  - br_taken: pc <= br_target; outstanding request abandoned; if imem_ack same cycle, word discarded (no instr_valid, no count).
  - halt: if imem_ack same cycle, deliver word and pc <= pc_inc_sum; else pc unchanged. State -> HALT.
  - stall: no change to pc or state.
  - imem_ack: instr <= imem_rdata, instr_pc <= pc, instr_valid=1 next cycle, fetch_count += 1, pc <= pc_inc_sum.
- HALT: imem_req=0; br_taken updates pc, stays HALT; resume -> FETCH. halt and resume both high: stay HALT.
- stall in BOOT/HALT has no effect.
- pc wraps: 16'hFFFE -> 16'h0000 via adder; no special handling.
- Reset mid-transaction: all state cleared immediately, request dropped; late ack after reset is ignored (imem_req=0).

## Timing
- Reset values: pc=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_count=0, misalign_err=0.
- First imem_req one cycle after first rising edge following rst_n release (BOOT cycle).
- Zero-wait memory (ack in same cycle as req): one instruction per cycle, sequential addresses +2.
- instr_valid asserted the cycle after the accepting ack, for exactly one cycle.
- Redirect: br_taken at edge N -> imem_addr=br_target from cycle N+1.
- halted rises the cycle after halt accepted; imem_req low the same cycle.

## Configuration
- PC_ALIGN_CHECK_EN defined: br_taken with br_target[0]=1 is not applied; pc unchanged, misalign_err set (sticky until reset), state -> HALT; any same-cycle ack discarded.
- Undefined: br_target[0] forced to 0 on load; misalign_err tied 0.

## Test plan
- Reset release, ack every cycle -> imem_addr 0000,0002,0004; instr_valid per cycle; fetch_count 3 after three acks.
- br_taken with br_target=16'h0100 coincident with ack at pc=0004 -> word dropped, next imem_addr=0100, fetch_count unchanged.
- stall high 3 cycles mid-stream -> imem_req low 3 cycles, pc held, fetch resumes at same address.
- pc=16'hFFFE, ack -> next imem_addr=0000; fetch_count 16'hFFFF + ack -> 0000.
- halt without ack -> halted=1, imem_req=0, pc held; br_taken 0040 in HALT then resume -> imem_addr=0040.
- PC_ALIGN_CHECK_EN: br_target=0101 -> misalign_err=1, halted=1, pc unchanged; without macro -> imem_addr=0100.
